// File: rtl/intr_ctrl_if.sv
// -----------------------------------------------------------------------------
// intr_ctrl_if
// CPU-side bus of the interrupt controller.
//   cfg_we / cfg_wdata : mask write strobe and new mask (1 = source enabled)
//   intr_ack           : CPU took the interrupt (single-cycle strobe)
//   intr_done          : CPU returned from the interrupt (single-cycle strobe)
//   External_intr      : registered interrupt request to the CPU
//   intr_cause         : registered index of the requested / serviced source
//   pending            : registered pending-request bits
//   mask               : registered current mask
// Modports: master = CPU side, slave = controller side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface intr_ctrl_if;
  logic       cfg_we;
  logic [3:0] cfg_wdata;
  logic       intr_ack;
  logic       intr_done;
  logic       External_intr;
  logic [1:0] intr_cause;
  logic [3:0] pending;
  logic [3:0] mask;

  modport master (
    output cfg_we,
    output cfg_wdata,
    output intr_ack,
    output intr_done,
    input  External_intr,
    input  intr_cause,
    input  pending,
    input  mask
  );

  modport slave (
    input  cfg_we,
    input  cfg_wdata,
    input  intr_ack,
    input  intr_done,
    output External_intr,
    output intr_cause,
    output pending,
    output mask
  );
endinterface

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
// Four-source, non-nesting interrupt controller.
//   clk    : system clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   irq_in : asynchronous interrupt sources, rising-edge sensitive,
//            bit 0 has the highest priority
//   bus    : CPU-side bus (intr_ctrl_if.slave), see the interface header
//
// Each source is synchronised (2 flops) and edge-detected against a third
// flop. Detected edges set pending bits regardless of the mask. A three-state
// FSM (IDLE/REQ/SERVICE) raises one request at a time for the lowest enabled
// pending index and waits for the CPU acknowledge and return strobes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module intr_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   irq_in,
  intr_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Lowest set index of a 4-bit vector; bit 0 wins.
  function automatic logic [1:0] lowest_idx(input logic [3:0] vec);
    logic [1:0] idx;
    if (vec[0]) begin
      idx = 2'd0;
    end else if (vec[1]) begin
      idx = 2'd1;
    end else if (vec[2]) begin
      idx = 2'd2;
    end else if (vec[3]) begin
      idx = 2'd3;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

  // One-hot decode of a 2-bit source index.
  function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [3:0] sync3_r;
  logic [1:0] settle_r;
  logic [3:0] arm_r;
  logic [3:0] pending_r;
  logic [3:0] mask_r;
  state_e     state_r;
  logic       ext_r;
  logic [1:0] cause_r;

  logic       settle_done_s;
  logic [3:0] edge_s;
  logic [3:0] req_vec_s;
  logic [3:0] ack_clr_s;
  logic [3:0] pending_nxt_s;

  // sync2_r only reflects a genuine sample of irq_in two edges after reset
  // release; before that its reset value of 0 must not count as "seen low".
  assign settle_done_s = (settle_r == 2'd2);

  // A source only produces edges once it has been seen low after reset, so a
  // level already high at reset release is not mistaken for a new edge.
  assign edge_s    = sync2_r & ~sync3_r & arm_r;
  assign req_vec_s = pending_r & mask_r;

  // Pending bit of the source being acknowledged; only an ack in REQ counts.
  always_comb begin
    ack_clr_s = 4'b0000;
    if ((state_r == ST_REQ) && bus.intr_ack) begin
      ack_clr_s = idx_onehot(cause_r);
    end else begin
      ack_clr_s = 4'b0000;
    end
  end

  // A new edge on the acknowledged bit in the same cycle keeps it pending.
  assign pending_nxt_s = (pending_r & ~ack_clr_s) | edge_s;

  // Input synchronizer plus the edge-detect delay stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      sync3_r <= 4'b0000;
    end else begin
      sync1_r <= irq_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Post-reset settle counter for the synchronizer pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_r <= 2'd0;
    end else if (!settle_done_s) begin
      settle_r <= settle_r + 2'd1;
    end else begin
      settle_r <= settle_r;
    end
  end

  // Per-source arm flag: set once the synchronised input has been seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_r <= 4'b0000;
    end else if (settle_done_s) begin
      arm_r <= arm_r | ~sync2_r;
    end else begin
      arm_r <= arm_r;
    end
  end

  // Pending request bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 4'b0000;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Mask register, loaded on the write strobe in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r <= 4'b1111;
    end else if (bus.cfg_we) begin
      mask_r <= bus.cfg_wdata;
    end else begin
      mask_r <= mask_r;
    end
  end

  // Request FSM with registered External_intr and intr_cause. The request
  // stays up in REQ until acknowledged, even if the mask changes meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ext_r   <= 1'b0;
      cause_r <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_vec_s != 4'b0000) begin
            state_r <= ST_REQ;
            ext_r   <= 1'b1;
            cause_r <= lowest_idx(req_vec_s);
          end else begin
            state_r <= ST_IDLE;
            ext_r   <= 1'b0;
            cause_r <= cause_r;
          end
        end
        ST_REQ: begin
          // An ack wins over a simultaneous done; done alone is ignored here.
          if (bus.intr_ack) begin
            state_r <= ST_SERVICE;
            ext_r   <= 1'b0;
          end else begin
            state_r <= ST_REQ;
            ext_r   <= 1'b1;
          end
          cause_r <= cause_r;
        end
        ST_SERVICE: begin
          if (bus.intr_done) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_SERVICE;
          end
          ext_r   <= 1'b0;
          cause_r <= cause_r;
        end
        default: begin
          state_r <= ST_IDLE;
          ext_r   <= 1'b0;
          cause_r <= 2'd0;
        end
      endcase
    end
  end

  assign bus.External_intr = ext_r;
  assign bus.intr_cause    = cause_r;
  assign bus.pending       = pending_r;
  assign bus.mask          = mask_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_ctrl
// Directed self-checking bench for intr_ctrl. Inputs change on the falling
// edge, outputs are sampled on the falling edge, away from the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_intr_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] irq_in;

  int checks;
  int failures;

  intr_ctrl_if bus ();

  intr_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_in (irq_in),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    bus.intr_ack = 1'b1;
    cyc(1);
    bus.intr_ack = 1'b0;
  endtask

  task automatic done_pulse();
    bus.intr_done = 1'b1;
    cyc(1);
    bus.intr_done = 1'b0;
  endtask

  task automatic mask_write(input logic [3:0] val);
    bus.cfg_we    = 1'b1;
    bus.cfg_wdata = val;
    cyc(1);
    bus.cfg_we    = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    irq_in        = 4'b0000;
    bus.cfg_we    = 1'b0;
    bus.cfg_wdata = 4'b0000;
    bus.intr_ack  = 1'b0;
    bus.intr_done = 1'b0;

    // Reset state
    cyc(2);
    chk("rst_ext",     32'(bus.External_intr), 32'd0);
    chk("rst_cause",   32'(bus.intr_cause),    32'd0);
    chk("rst_pending", 32'(bus.pending),       32'h0);
    chk("rst_mask",    32'(bus.mask),          32'hF);
    rst_n = 1'b1;
    cyc(4);

    // Single source: pending at k+2, request at k+3
    irq_in[2] = 1'b1;
    cyc(2);
    chk("t1_pend_k1",  32'(bus.pending),       32'h0);
    cyc(1);
    chk("t1_pend_k2",  32'(bus.pending),       32'h4);
    chk("t1_ext_k2",   32'(bus.External_intr), 32'd0);
    cyc(1);
    chk("t1_ext_k3",   32'(bus.External_intr), 32'd1);
    chk("t1_cause_k3", 32'(bus.intr_cause),    32'd2);
    ack_pulse();
    chk("t1_ext_ack",  32'(bus.External_intr), 32'd0);
    chk("t1_pend_ack", 32'(bus.pending),       32'h0);
    cyc(3);
    chk("t1_ext_svc",  32'(bus.External_intr), 32'd0);
    done_pulse();
    cyc(4);
    chk("t1_level_pend", 32'(bus.pending),       32'h0);
    chk("t1_level_ext",  32'(bus.External_intr), 32'd0);
    irq_in[2] = 1'b0;
    cyc(3);

    // Two sources together: priority, ack clear, one IDLE cycle gap
    irq_in = 4'b1010;
    cyc(4);
    chk("t2_ext",       32'(bus.External_intr), 32'd1);
    chk("t2_cause",     32'(bus.intr_cause),    32'd1);
    chk("t2_pend",      32'(bus.pending),       32'hA);
    ack_pulse();
    chk("t2_pend_ack",  32'(bus.pending),       32'h8);
    chk("t2_ext_ack",   32'(bus.External_intr), 32'd0);
    done_pulse();
    chk("t2_idle_gap",  32'(bus.External_intr), 32'd0);
    chk("t2_cause_hold",32'(bus.intr_cause),    32'd1);
    cyc(1);
    chk("t2_ext_next",  32'(bus.External_intr), 32'd1);
    chk("t2_cause_next",32'(bus.intr_cause),    32'd3);
    ack_pulse();
    done_pulse();
    irq_in = 4'b0000;
    cyc(3);

    // Masked source stays pending, request after unmasking
    mask_write(4'b1110);
    chk("t3_mask",      32'(bus.mask),          32'hE);
    irq_in[0] = 1'b1;
    cyc(3);
    chk("t3_pend",      32'(bus.pending),       32'h1);
    cyc(3);
    chk("t3_ext_masked",32'(bus.External_intr), 32'd0);
    mask_write(4'b1111);
    chk("t3_mask_on",   32'(bus.mask),          32'hF);
    chk("t3_ext_wr",    32'(bus.External_intr), 32'd0);
    cyc(1);
    chk("t3_ext_req",   32'(bus.External_intr), 32'd1);
    chk("t3_cause",     32'(bus.intr_cause),    32'd0);
    ack_pulse();
    done_pulse();
    irq_in = 4'b0000;
    cyc(3);

    // No nesting in SERVICE; ack+done together in REQ honours only ack
    irq_in[2] = 1'b1;
    cyc(4);
    chk("t4_ext",       32'(bus.External_intr), 32'd1);
    chk("t4_cause",     32'(bus.intr_cause),    32'd2);
    ack_pulse();
    irq_in[0] = 1'b1;
    irq_in[3] = 1'b1;
    cyc(5);
    chk("t4_pend_svc",  32'(bus.pending),       32'h9);
    chk("t4_ext_svc",   32'(bus.External_intr), 32'd0);
    done_pulse();
    chk("t4_idle_gap",  32'(bus.External_intr), 32'd0);
    cyc(1);
    chk("t4_ext_re",    32'(bus.External_intr), 32'd1);
    chk("t4_cause_re",  32'(bus.intr_cause),    32'd0);
    bus.intr_ack  = 1'b1;
    bus.intr_done = 1'b1;
    cyc(1);
    bus.intr_ack  = 1'b0;
    bus.intr_done = 1'b0;
    chk("t4_ackdone_ext", 32'(bus.External_intr), 32'd0);
    chk("t4_ackdone_pend",32'(bus.pending),       32'h8);
    cyc(3);
    chk("t4_done_ignored",32'(bus.External_intr), 32'd0);
    done_pulse();
    cyc(1);
    chk("t4_ext_c3",    32'(bus.External_intr), 32'd1);
    chk("t4_cause_c3",  32'(bus.intr_cause),    32'd3);
    ack_pulse();
    done_pulse();
    irq_in = 4'b0000;
    cyc(3);

    // Edge coincident with ack of the same bit: set wins
    irq_in[1] = 1'b1;
    cyc(4);
    chk("t5_ext",       32'(bus.External_intr), 32'd1);
    chk("t5_cause",     32'(bus.intr_cause),    32'd1);
    chk("t5_pend",      32'(bus.pending),       32'h2);
    irq_in[1] = 1'b0;
    cyc(3);
    irq_in[1] = 1'b1;
    cyc(2);
    ack_pulse();
    chk("t5_setwins",   32'(bus.pending),       32'h2);
    chk("t5_ext_ack",   32'(bus.External_intr), 32'd0);
    done_pulse();
    cyc(1);
    chk("t5_ext_re",    32'(bus.External_intr), 32'd1);
    chk("t5_cause_re",  32'(bus.intr_cause),    32'd1);
    ack_pulse();
    chk("t5_pend_clr",  32'(bus.pending),       32'h0);
    done_pulse();
    // Stray strobes in IDLE
    ack_pulse();
    chk("t5_stray_ack_ext",  32'(bus.External_intr), 32'd0);
    chk("t5_stray_ack_pend", 32'(bus.pending),       32'h0);
    done_pulse();
    chk("t5_stray_done_ext", 32'(bus.External_intr), 32'd0);
    irq_in = 4'b0100;
    cyc(4);
    chk("t5_after_stray_ext",   32'(bus.External_intr), 32'd1);
    chk("t5_after_stray_cause", 32'(bus.intr_cause),    32'd2);
    // Done in REQ ignored; mask change in REQ keeps the request
    done_pulse();
    chk("t5_done_in_req", 32'(bus.External_intr), 32'd1);
    mask_write(4'b0000);
    chk("t5_mask0",       32'(bus.mask),          32'h0);
    chk("t5_mask0_ext",   32'(bus.External_intr), 32'd1);
    chk("t5_mask0_cause", 32'(bus.intr_cause),    32'd2);

    // Asynchronous reset while requesting, held level after release
    irq_in[0] = 1'b1;
    cyc(4);
    chk("t6_pend_pre",  32'(bus.pending),       32'h5);
    chk("t6_ext_pre",   32'(bus.External_intr), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ext",   32'(bus.External_intr), 32'd0);
    chk("t6_rst_pend",  32'(bus.pending),       32'h0);
    chk("t6_rst_mask",  32'(bus.mask),          32'hF);
    chk("t6_rst_cause", 32'(bus.intr_cause),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(8);
    chk("t6_held_ext",  32'(bus.External_intr), 32'd0);
    chk("t6_held_pend", 32'(bus.pending),       32'h0);
    irq_in[0] = 1'b0;
    cyc(3);
    irq_in[0] = 1'b1;
    cyc(4);
    chk("t6_retrig_ext",   32'(bus.External_intr), 32'd1);
    chk("t6_retrig_cause", 32'(bus.intr_cause),    32'd0);
    chk("t6_retrig_pend",  32'(bus.pending),       32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The module SHALL have one clock and reset SHALL be asynchronous and active-low; ports follow.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 irq_in  input  4  asynchronous interrupt sources, rising-edge sensitive; bit 0 highest priority.
REQ-005 cfg_we  input  1  mask write strobe.
REQ-006 cfg_wdata  input  4  new mask value, 1 = source enabled.
REQ-007 intr_ack  input  1  CPU single-cycle acknowledge (interrupt taken, EPC saved).
REQ-008 intr_done  input  1  CPU single-cycle return-from-interrupt strobe.
REQ-009 External_intr  output  1  registered interrupt request to CPU.
REQ-010 intr_cause  output  2  registered index of the source being requested or serviced.
REQ-011 pending  output  4  registered pending-request bits.
REQ-012 mask  output  4  registered current mask.

Function
REQ-013 Each irq_in bit SHALL pass through a 2-flop synchronizer followed by a third flop; rising edge = sync2 & ~sync3.
REQ-014 irq_in high before clock edge k SHALL set pending on edge k+2; External_intr SHALL be high from edge k+3 if the state is IDLE and the bit is enabled.
REQ-015 A level held high SHALL produce exactly one pending set; re-trigger requires a low then high level of at least 2 cycles each.
REQ-016 Pending bits SHALL be set regardless of mask; mask only gates requesting.
REQ-017 FSM states: IDLE, REQ, SERVICE.
REQ-018 IDLE -> REQ when (pending & mask) != 0; intr_cause SHALL latch the lowest set index of (pending & mask) on this transition; External_intr = 1 while in REQ.
REQ-019 REQ -> SERVICE on intr_ack; pending[intr_cause] SHALL clear on that edge; External_intr SHALL be 0 from the next cycle.
REQ-020 SERVICE -> IDLE on intr_done; intr_cause holds its value through SERVICE and IDLE until the next REQ entry.
REQ-021 No new request SHALL be raised in REQ or SERVICE; arriving edges only set pending (no nesting).
REQ-022 intr_ack outside REQ and intr_done outside SERVICE SHALL be ignored.
REQ-023 intr_ack and intr_done in the same cycle in REQ: ack is honoured, done is ignored.
REQ-024 Edge detect and ack-clear on the same bit in the same cycle: pending SHALL remain 1 (set wins).
REQ-025 cfg_we SHALL load mask on that edge; a mask change in REQ SHALL NOT abort the request or change intr_cause.
REQ-026 After SERVICE -> IDLE with (pending & mask) != 0, REQ SHALL be entered on the following edge (one IDLE cycle minimum).

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, External_intr 0, intr_cause 0, pending 0, mask 4'b1111, and synchronizer flops 0.
REQ-028 Reset deasserted mid-REQ or mid-SERVICE SHALL restart from IDLE with no stale request; an irq_in already high at release SHALL NOT register as an edge until it goes low and then high again.

Verification
REQ-029 Reset, then irq_in[2] 0->1 before edge k -> pending=4'b0100 at k+2, External_intr=1 and intr_cause=2 at k+3.
REQ-030 irq_in[3] and irq_in[1] rise together -> intr_cause=1; ack -> pending=4'b1000; done -> next REQ with intr_cause=3 after one IDLE cycle.
REQ-031 mask=4'b1110, irq_in[0] rises -> pending[0]=1, External_intr stays 0; write mask=4'b1111 -> REQ entered next edge with intr_cause=0.
REQ-032 In SERVICE(cause 2), irq_in[0] rises -> External_intr stays 0; done -> REQ with cause 0.
REQ-033 Edge on irq_in[1] coincident with ack of cause 1 -> pending[1] still 1 after the ack edge; stray intr_ack in IDLE -> no state change.
REQ-034 rst_n pulsed low while External_intr=1 -> External_intr=0, pending=0, mask=4'b1111 asynchronously; held irq_in high -> no request after release.
